// File: rtl/zeroriscy_register_file_mp_if.sv
// Bus bundle for the multi-port zero-riscy register file: read/write ports,
// clear handshake and dropped-write error pulse.
interface zeroriscy_register_file_mp_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2
);
  logic [NUM_RD*5-1:0]          raddr_i;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_o;
  logic [NUM_WR*5-1:0]          waddr_i;
  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_WR-1:0]            we_i;
  logic                         clear_req_i;
  logic                         clear_busy_o;
  logic                         clear_done_o;
  logic                         err_o;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i, clear_req_i,
    input  rdata_o, clear_busy_o, clear_done_o, err_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i, clear_req_i,
    output rdata_o, clear_busy_o, clear_done_o, err_o
  );
endinterface

// File: rtl/zeroriscy_register_file_mp.sv
// Flip-flop register file with NUM_RD read / NUM_WR write ports, optional
// write-to-read bypass and a one-register-per-cycle hardware clear engine.
module zeroriscy_register_file_mp #(
  parameter int unsigned RV32E      = 0,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned BYPASS     = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  zeroriscy_register_file_mp_if.slave bus
);

  localparam int unsigned ADDR_WIDTH = (RV32E != 0) ? 4 : 5;
  localparam int unsigned NUM_WORDS  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [DATA_WIDTH-1:0]   mem_q [NUM_WORDS-1:1];
  logic [DATA_WIDTH-1:0]   mem_d [NUM_WORDS-1:1];

  logic [4:0]              wr_addr [NUM_WR];
  logic [DATA_WIDTH-1:0]   wr_data [NUM_WR];
  logic [NUM_WR-1:0]       wr_acc;
  logic [NUM_WR-1:0]       wr_drop;

  logic [4:0]              rd_addr [NUM_RD];
  logic [DATA_WIDTH-1:0]   rd_val  [NUM_RD];
  logic [NUM_RD*DATA_WIDTH-1:0] rdata_all;

  // RV32E only maps the lower half of the 5-bit architectural address space.
  function automatic logic addr_legal(input logic [4:0] a);
    return (RV32E == 0) ? 1'b1 : ~a[4];
  endfunction

  always_comb begin
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wr_addr[p] = bus.waddr_i[5*p +: 5];
      wr_data[p] = bus.wdata_i[DATA_WIDTH*p +: DATA_WIDTH];
    end
  end

  always_comb begin
    wr_acc  = '0;
    wr_drop = '0;
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wr_acc[p]  = bus.we_i[p] & addr_legal(wr_addr[p]) &
                   (wr_addr[p] != 5'd0) & (state_q == S_IDLE);
      wr_drop[p] = bus.we_i[p] & (~addr_legal(wr_addr[p]) | (state_q == S_CLEAR));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = |wr_drop;
    unique case (state_q)
      S_IDLE: begin
        if (bus.clear_req_i) begin
          state_d = S_CLEAR;
          cnt_d   = CNT_ONE;
        end
      end
      S_CLEAR: begin
        if (cnt_q == '1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Later write ports override earlier ones by iterating in ascending order.
  always_comb begin
    for (int unsigned i = 1; i < NUM_WORDS; i++) begin
      mem_d[i] = mem_q[i];
      if (state_q == S_CLEAR) begin
        if (cnt_q == ADDR_WIDTH'(i)) mem_d[i] = '0;
      end else begin
        for (int unsigned p = 0; p < NUM_WR; p++) begin
          if (wr_acc[p] && (wr_addr[p][ADDR_WIDTH-1:0] == ADDR_WIDTH'(i))) begin
            mem_d[i] = wr_data[p];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NUM_WORDS; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    rdata_all = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_addr[r] = bus.raddr_i[5*r +: 5];
      rd_val[r]  = '0;
      if (addr_legal(rd_addr[r]) && (rd_addr[r] != 5'd0)) begin
        rd_val[r] = mem_q[rd_addr[r][ADDR_WIDTH-1:0]];
        if (BYPASS != 0) begin
          for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wr_acc[p] && (wr_addr[p] == rd_addr[r])) rd_val[r] = wr_data[p];
          end
        end
      end
      rdata_all[DATA_WIDTH*r +: DATA_WIDTH] = rd_val[r];
    end
  end

  assign bus.rdata_o      = rdata_all;
  assign bus.clear_busy_o = (state_q == S_CLEAR);
  assign bus.clear_done_o = done_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_zeroriscy_register_file_mp.sv
// Bench for zeroriscy_register_file_mp: two configurations (RV32I+bypass,
// RV32E without bypass) driven in lockstep and checked against a reference model.
module tb_zeroriscy_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  we;
  logic        clear_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zeroriscy_register_file_mp_if #(.DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2)) bus0 ();
  zeroriscy_register_file_mp_if #(.DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2)) bus1 ();

  assign bus0.raddr_i = raddr;  assign bus1.raddr_i = raddr;
  assign bus0.waddr_i = waddr;  assign bus1.waddr_i = waddr;
  assign bus0.wdata_i = wdata;  assign bus1.wdata_i = wdata;
  assign bus0.we_i    = we;     assign bus1.we_i    = we;
  assign bus0.clear_req_i = clear_req;
  assign bus1.clear_req_i = clear_req;

  zeroriscy_register_file_mp #(.RV32E(0), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  zeroriscy_register_file_mp #(.RV32E(1), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Reference model: config 0 = 32 regs with bypass, config 1 = 16 regs without.
  logic [31:0] m_reg [2][32];
  int          m_clr [2];   // 0 when idle, else the register cleared at the next edge
  logic        m_done [2];
  logic        m_err  [2];

  function automatic int nw(input int c);
    return (c == 0) ? 32 : 16;
  endfunction

  function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0 || int'(a) >= nw(c)) return 32'd0;
    v = m_reg[c][a];
    if (c == 0 && m_clr[c] == 0) begin
      for (int p = 0; p < 2; p++)
        if (we[p] && waddr[5*p +: 5] == a) v = wdata[32*p +: 32];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) m_reg[c][i] = 32'd0;
      m_clr[c] = 0; m_done[c] = 1'b0; m_err[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [4:0] a;
    logic       e;
    for (int c = 0; c < 2; c++) begin
      e = 1'b0;
      for (int p = 0; p < 2; p++) begin
        a = waddr[5*p +: 5];
        if (we[p]) begin
          if (m_clr[c] != 0 || int'(a) >= nw(c)) e = 1'b1;
          else if (a != 5'd0) m_reg[c][a] = wdata[32*p +: 32];
        end
      end
      m_err[c]  = e;
      m_done[c] = (m_clr[c] == nw(c) - 1);
      if (m_clr[c] == 0) begin
        if (clear_req) m_clr[c] = 1;
      end else begin
        m_reg[c][m_clr[c]] = 32'd0;
        m_clr[c] = (m_clr[c] == nw(c) - 1) ? 0 : m_clr[c] + 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("cfg0_rd0", bus0.rdata_o[31:0],  exp_rd(0, raddr[4:0]));
    chk("cfg0_rd1", bus0.rdata_o[63:32], exp_rd(0, raddr[9:5]));
    chk("cfg1_rd0", bus1.rdata_o[31:0],  exp_rd(1, raddr[4:0]));
    chk("cfg1_rd1", bus1.rdata_o[63:32], exp_rd(1, raddr[9:5]));
    chk("cfg0_busy", 32'(bus0.clear_busy_o), 32'(m_clr[0] != 0));
    chk("cfg1_busy", 32'(bus1.clear_busy_o), 32'(m_clr[1] != 0));
    chk("cfg0_done", 32'(bus0.clear_done_o), 32'(m_done[0]));
    chk("cfg1_done", 32'(bus1.clear_done_o), 32'(m_done[1]));
    chk("cfg0_err",  32'(bus0.err_o), 32'(m_err[0]));
    chk("cfg1_err",  32'(bus1.err_o), 32'(m_err[1]));
  endtask

  task automatic step();
    #2;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we = 2'b00; waddr = '0; wdata = '0; raddr = '0; clear_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0r0, e0r1, e1r0;
    logic        e_err1;
  } vec_t;

  vec_t tbl [8];
  int   b0, b1, d0, d1;

  initial begin
    tbl[0] = '{2'b11, 5'd5,  5'd6, 32'hDEADBEEF, 32'h12345678, 5'd5,  5'd0,
               32'hDEADBEEF, 32'h0, 32'h0, 1'b0};
    tbl[1] = '{2'b00, 5'd0,  5'd0, 32'h0, 32'h0, 5'd5, 5'd6,
               32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{2'b11, 5'd7,  5'd7, 32'hAAAA0000, 32'h0000BBBB, 5'd7, 5'd0,
               32'h0000BBBB, 32'h0, 32'h0, 1'b0};
    tbl[3] = '{2'b00, 5'd0,  5'd0, 32'h0, 32'h0, 5'd7, 5'd6,
               32'h0000BBBB, 32'h12345678, 32'h0000BBBB, 1'b0};
    tbl[4] = '{2'b01, 5'd0,  5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd7,
               32'h0, 32'h0000BBBB, 32'h0, 1'b0};
    tbl[5] = '{2'b01, 5'd20, 5'd0, 32'h1, 32'h0, 5'd20, 5'd5,
               32'h1, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[6] = '{2'b00, 5'd0,  5'd0, 32'h0, 32'h0, 5'd20, 5'd0,
               32'h1, 32'h0, 32'h0, 1'b1};
    tbl[7] = '{2'b00, 5'd0,  5'd0, 32'h0, 32'h0, 5'd5, 5'd15,
               32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0};

    do_reset();

    // Directed vectors: basic write/read, collision, bypass, x0, RV32E range.
    for (int v = 0; v < 8; v++) begin
      we = tbl[v].we; clear_req = 1'b0;
      waddr = {tbl[v].wa1, tbl[v].wa0};
      wdata = {tbl[v].wd1, tbl[v].wd0};
      raddr = {tbl[v].ra1, tbl[v].ra0};
      #1;
      chk($sformatf("vec%0d_cfg0_rd0", v), bus0.rdata_o[31:0],  tbl[v].e0r0);
      chk($sformatf("vec%0d_cfg0_rd1", v), bus0.rdata_o[63:32], tbl[v].e0r1);
      chk($sformatf("vec%0d_cfg1_rd0", v), bus1.rdata_o[31:0],  tbl[v].e1r0);
      chk($sformatf("vec%0d_cfg1_err", v), 32'(bus1.err_o), 32'(tbl[v].e_err1));
      chk($sformatf("vec%0d_cfg0_err", v), 32'(bus0.err_o), 32'h0);
      step();
    end

    // Clear sequence: fill x1..x31 with their index, then clear.
    for (int i = 1; i < 32; i += 2) begin
      idle_inputs();
      waddr = {5'(i + 1), 5'(i)};
      wdata = {32'(i + 1), 32'(i)};
      we    = (i + 1 < 32) ? 2'b11 : 2'b01;
      raddr = {5'(i), 5'(i - 1)};
      step();
    end
    idle_inputs();
    clear_req = 1'b1;
    step();
    b0 = 0; b1 = 0; d0 = 0; d1 = 0;
    for (int k = 0; k < 40; k++) begin
      idle_inputs();
      raddr = {5'd3, 5'd1};
      clear_req = (k == 5);
      if (k == 9) begin we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h33}; end
      #1;
      if (k == 0) chk("x1_before_first_clear", bus0.rdata_o[31:0], 32'd1);
      if (k == 1) chk("x1_after_first_clear", bus0.rdata_o[31:0], 32'd0);
      if (k == 10) chk("err_after_midclear_write", 32'(bus0.err_o), 32'd1);
      if (bus0.clear_busy_o) b0++;
      if (bus1.clear_busy_o) b1++;
      if (bus0.clear_done_o) d0++;
      if (bus1.clear_done_o) d1++;
      step();
    end
    chk("busy_len_cfg0", 32'(b0), 32'd31);
    chk("busy_len_cfg1", 32'(b1), 32'd15);
    chk("done_count_cfg0", 32'(d0), 32'd1);
    chk("done_count_cfg1", 32'(d1), 32'd1);
    for (int i = 0; i < 32; i += 2) begin
      idle_inputs();
      raddr = {5'(i + 1), 5'(i)};
      #1;
      chk($sformatf("cleared_x%0d", i + 1), bus0.rdata_o[63:32], 32'd0);
      step();
    end

    // Clear requested in the done cycle restarts immediately.
    idle_inputs(); clear_req = 1'b1; step();
    idle_inputs();
    for (int k = 0; k < 31; k++) step();
    idle_inputs(); #1;
    chk("done_pulse_cfg0", 32'(bus0.clear_done_o), 32'd1);
    clear_req = 1'b1; step();
    idle_inputs(); #1;
    chk("restart_from_done", 32'(bus0.clear_busy_o), 32'd1);
    for (int k = 0; k < 32; k++) step();

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      we        = 2'($urandom_range(0, 3));
      waddr     = 10'($urandom);
      wdata     = {32'($urandom), 32'($urandom)};
      raddr     = ($urandom_range(0, 2) == 0) ? waddr : 10'($urandom);
      clear_req = ($urandom_range(0, 39) == 0);
      step();
    end

    // Reset in the middle of a clear.
    idle_inputs();
    for (int i = 1; i < 32; i++) begin
      we = 2'b01; waddr = {5'd0, 5'(i)}; wdata = {32'h0, 32'hC0DE0000 | 32'(i)};
      step();
    end
    idle_inputs(); clear_req = 1'b1; step();
    idle_inputs();
    for (int k = 0; k < 10; k++) step();
    raddr = {5'd30, 5'd20};
    #1;
    chk("pre_reset_x20_live", bus0.rdata_o[31:0], 32'hC0DE0014);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_busy_immediate", 32'(bus0.clear_busy_o), 32'd0);
    check_outputs();
    for (int i = 0; i < 32; i += 2) begin
      raddr = {5'(i + 1), 5'(i)};
      #1;
      check_outputs();
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_inputs();
    d0 = 0;
    for (int k = 0; k < 40; k++) begin
      raddr = {5'(k % 32), 5'((k + 7) % 32)};
      #1;
      if (bus0.clear_done_o || bus1.clear_done_o) d0++;
      step();
    end
    chk("no_done_after_reset", 32'(d0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zeroriscy_register_file_mp.md
Name: zeroriscy_register_file_mp

Overview:
Next-generation flip-flop register file for the zero-riscy core. It is parametrised in data width, read-port count and write-port count, and keeps RV32E support. It adds optional write-to-read bypass, a sequential hardware clear engine that zeroes every architectural register one per cycle, and a sticky-free error pulse for dropped writes. It sits in the ID stage in place of the single-write latch register file and feeds the operand muxes.

Parameters:
RV32E, 0, 1 selects 16 registers (ADDR_WIDTH 4); 0 selects 32 registers (ADDR_WIDTH 5)
DATA_WIDTH, 32, register width in bits
NUM_RD, 2, number of read ports (legal 1..4)
NUM_WR, 2, number of write ports (legal 1..2)
BYPASS, 1, 1 forwards same-cycle write data to matching reads; 0 returns stored data

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
raddr_i  input  NUM_RD*5  read addresses; port r uses bits [5r+4:5r]
rdata_o  output  NUM_RD*DATA_WIDTH  read data; port r uses bits [DATA_WIDTH*(r+1)-1:DATA_WIDTH*r]
waddr_i  input  NUM_WR*5  write addresses, packed the same way as raddr_i
wdata_i  input  NUM_WR*DATA_WIDTH  write data, packed per port
we_i  input  NUM_WR  write enable per port
clear_req_i  input  1  single-cycle request to zero the whole file
clear_busy_o  output  1  clear engine active
clear_done_o  output  1  one-cycle pulse when a clear completes
err_o  output  1  one-cycle pulse: a write was dropped in the previous cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all registers 0, FSM in IDLE, counter 0, clear_busy_o 0, clear_done_o 0, err_o 0.
- Storage:
  - NUM_WORDS = 2**ADDR_WIDTH; register 0 has no storage and always reads 0.
  - Registers 1..NUM_WORDS-1 are rising-edge flops.
- Address legality:
  - RV32E=1: any 5-bit address with bit 4 set is out of range.
  - Out-of-range reads return 0.
  - Out-of-range writes are dropped.
- Writes:
  - Take effect at the rising edge where we_i[p]=1, the address is legal and nonzero, and the FSM is IDLE.
  - A write to address 0 is a silent no-op, not an error.
  - If both ports write the same address in the same cycle, port NUM_WR-1 wins.
- Reads:
  - Combinational, zero latency.
  - BYPASS=1: if a write accepted this cycle targets the read address (nonzero), rdata is that wdata, using the same port priority.
  - Otherwise rdata is the stored value.
  - Reads of address 0 always return 0, even with a same-cycle write to 0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_req_i=1. The counter loads 1.
  - In CLEAR, each cycle zeroes register[counter] and increments the counter. Register i is zero after edge t+i, where t is the request edge.
  - CLEAR -> IDLE on the edge that zeroes register NUM_WORDS-1. clear_done_o is high for the following cycle.
  - clear_busy_o = (state==CLEAR). It is high for exactly NUM_WORDS-1 cycles: 31 for RV32E=0, 15 for RV32E=1.
  - clear_req_i while in CLEAR is ignored; the request is not queued.
  - clear_req_i in the cycle clear_done_o is high starts a new clear.
  - Reads during CLEAR return the current, partially cleared contents. Bypass is inactive because no writes are accepted.
- Dropped writes:
  - A write is dropped if we_i[p]=1 and either the FSM is in CLEAR or the address is out of range.
  - Any dropped write in cycle c makes err_o=1 in cycle c+1 only.
- Reset mid-clear: rst_n low aborts immediately. The FSM goes to IDLE, all outputs go to 0, and all registers go to 0.
- Width rules: no arithmetic on data. The counter is ADDR_WIDTH bits wide and never wraps, because it terminates at NUM_WORDS-1.

Test Plan:
1. Basic write/read, NUM_WR=2: write 0xDEADBEEF to x5 via port 0 and 0x12345678 to x6 via port 1 in the same cycle. Next cycle read x5 and x6 -> 0xDEADBEEF and 0x12345678. Read x0 -> 0.
2. Write collision and bypass: both ports write x7, port 0 with 0xAAAA0000 and port 1 with 0x0000BBBB. Same-cycle read of x7 with BYPASS=1 -> 0x0000BBBB. With BYPASS=0 -> old value. Stored value afterwards -> 0x0000BBBB.
3. x0 protection: write 0xFFFFFFFF to x0 -> read 0 (BYPASS=1 as well), err_o stays 0.
4. RV32E out of range: with RV32E=1, write 0x1 to address 20 -> err_o=1 for one cycle, read of address 20 -> 0, registers 1..15 unchanged.
5. Clear sequence: fill x1..x31 with value i, pulse clear_req_i -> clear_busy_o high for 31 cycles and x1 zero after the first edge. A write to x3 mid-clear -> err_o pulse and x3 ends at 0. clear_done_o pulses once, then all reads return 0.
6. Reset mid-clear: deassert rst_n 10 cycles into a clear -> clear_busy_o=0 immediately and all registers 0. After reset release with no request, clear_done_o never pulses.
